// File: rtl/alu_pkg.sv
// Shared decode constants and stage state type for the ALU operand path.
// Optional ILLEGAL_TRAP_EN build uses is_legal() to flag unsupported instructions.
package alu_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic fn_ok;
        fn_ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                (fn == FN_OR)  || (fn == FN_NOR) || (fn == FN_SLT);
        case (op)
            OP_RTYPE:             is_legal = fn_ok;
            OP_BEQ, OP_LW, OP_SW: is_legal = 1'b1;
            default:              is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// 2-read/1-write register file: async reads, sync write, sync reset.
// Register 0 always reads 0 and is never written.
module reg_file_2r1w
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_raddr_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [REG_N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Instruction decode + operand fetch stage feeding the ALU through a valid/ready register.
// Define ILLEGAL_TRAP_EN to add the registered 'illegal' output.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [5:0]        func_field,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [REG_AW-1:0] dest,
    output logic              dest_we
`ifdef ILLEGAL_TRAP_EN
   ,output logic              illegal
`endif
);

    stage_state_t r_state, w_state_nxt;

    logic              w_accept, w_xfer;
    logic [5:0]        w_op, w_fn;
    logic [REG_AW-1:0] w_rs, w_rt, w_rd;
    logic [DATA_W-1:0] w_rd_a, w_rd_b, w_rs_val, w_rt_val, w_sext;
    logic [DATA_W-1:0] w_b;
    logic [REG_AW-1:0] w_dest;
    logic              w_we, w_ill;

    assign w_op   = instr[31:26];
    assign w_rs   = instr[25:21];
    assign w_rt   = instr[20:16];
    assign w_rd   = instr[15:11];
    assign w_fn   = instr[5:0];
    assign w_sext = {{(DATA_W-16){instr[15]}}, instr[15:0]};

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = out_valid && out_ready;

    reg_file_2r1w #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b),
        .i_we      (wb_en),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data)
    );

    // A write landing in the same cycle as the read must win over the stale array value.
    assign w_rs_val = (wb_en && (wb_addr == w_rs) && (w_rs != '0)) ? wb_data : w_rd_a;
    assign w_rt_val = (wb_en && (wb_addr == w_rt) && (w_rt != '0)) ? wb_data : w_rd_b;

`ifdef ILLEGAL_TRAP_EN
    assign w_ill = !is_legal(w_op, w_fn);
`else
    assign w_ill = 1'b0;
`endif

    always_comb begin
        w_b    = w_rt_val;
        w_dest = '0;
        w_we   = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_dest = w_rd;
                w_we   = 1'b1;
            end
            OP_LW: begin
                w_b    = w_sext;
                w_dest = w_rt;
                w_we   = 1'b1;
            end
            OP_SW:   w_b = w_sext;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (w_xfer && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opcode     <= '0;
            func_field <= '0;
            A          <= '0;
            B          <= '0;
            dest       <= '0;
            dest_we    <= 1'b0;
        end else if (w_accept) begin
            opcode     <= w_op;
            func_field <= w_fn;
            A          <= w_rs_val;
            B          <= w_b;
            dest       <= w_dest;
            dest_we    <= w_we && (w_dest != '0) && !w_ill;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (w_accept) begin
            illegal <= w_ill;
        end
    end
`endif

endmodule
